mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_port_arb_pkg.sv | 26 ++
 rtl/mem_port_arb_rr_arbiter.sv | 22 ++
 rtl/mem_port_arb.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM states and sizing helpers.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_RDW  = 2'd2,
    ST_WR   = 2'd3
  } state_t;

  // Width of a byte-count field: two bits cover up to three bytes, four needs three.
  function automatic int cnt_width(input int maxb);
    return (maxb <= 3) ? 2 : 3;
  endfunction

  // A zero count still moves one byte; counts above the maximum are clamped.
  function automatic int eff_count(input int cnt, input int maxb);
    if (cnt == 0)
      return 1;
    else if (cnt > maxb)
      return maxb;
    else
      return cnt;
  endfunction

endpackage

// File: rtl/mem_port_arb_rr_arbiter.sv
// Combinational round-robin selector: the search starts one port past the last grant.
module rr_arbiter #(
  parameter int NPORT = 4,
  parameter int IDXW  = 2
) (
  input  logic [NPORT-1:0] req,
  input  logic [IDXW-1:0]  last,
  output logic [NPORT-1:0] gnt
);

  // Walk the ports in priority order and grant the first one that is requesting.
  always_comb begin
    gnt = '0;
    for (int i = 1; i <= NPORT; i++) begin
      for (int p = 0; p < NPORT; p++) begin
        if (p == ((int'(last) + i) % NPORT) && req[p] && (gnt == '0))
          gnt[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates several multi-byte read ports and one write port onto a single-byte
// synchronous RAM. Writes have absolute priority; reads are served round-robin.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter  int NPORT = 4,
  parameter  int ADR_W = 16,
  parameter  int MAXB  = 3,
  localparam int CNT_W = cnt_width(MAXB)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NPORT-1:0]       rreq_i,
  input  logic [NPORT*ADR_W-1:0] radr_i,
  input  logic [NPORT*CNT_W-1:0] rcnt_i,
  output logic [NPORT-1:0]       rack_o,
  output logic [MAXB*8-1:0]      rdat_o,
  input  logic                   wreq_i,
  input  logic [ADR_W-1:0]       wadr_i,
  input  logic [CNT_W-1:0]       wcnt_i,
  input  logic [MAXB*8-1:0]      wdat_i,
  output logic                   wack_o,
  output logic                   stl_o,
  output logic [ADR_W-1:0]       mem_adr_o,
  output logic                   mem_we_o,
  output logic [7:0]             mem_wdat_o,
  input  logic [7:0]             mem_rdat_i
);

  localparam int IDXW = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_t               state;
  logic [IDXW-1:0]      last_gnt;
  logic [NPORT-1:0]     cur_gnt;
  logic [CNT_W-1:0]     k;
  logic [CNT_W-1:0]     last_k;
  logic [CNT_W-1:0]     cap_idx;
  logic [MAXB*8-1:0]    rbuf;
  logic [MAXB*8-1:0]    wbuf;
  logic [MAXB*8-1:0]    merged;

  logic [NPORT-1:0]     rreq_live;
  logic                 wreq_live;
  logic [NPORT-1:0]     gnt;
  logic [ADR_W-1:0]     sel_adr;
  logic [CNT_W-1:0]     sel_cnt;
  logic [IDXW-1:0]      sel_idx;

  // A request acknowledged this cycle is already served and must not be granted again.
  assign rreq_live = rreq_i & ~rack_o;
  assign wreq_live = wreq_i & ~wack_o;

  assign stl_o = (state != ST_IDLE) || (|rreq_live) || wreq_live;

  rr_arbiter #(
    .NPORT (NPORT),
    .IDXW  (IDXW)
  ) u_rr (
    .req  (rreq_live),
    .last (last_gnt),
    .gnt  (gnt)
  );

  // Pick out the granted port's address, count and index from the packed buses.
  always_comb begin
    sel_adr = '0;
    sel_cnt = '0;
    sel_idx = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (gnt[p]) begin
        sel_adr = radr_i[p*ADR_W +: ADR_W];
        sel_cnt = rcnt_i[p*CNT_W +: CNT_W];
        sel_idx = IDXW'(p);
      end
    end
  end

  // Read buffer with the byte currently arriving from the RAM dropped into its slot.
  always_comb begin
    merged = rbuf;
    for (int b = 0; b < MAXB; b++) begin
      if (cap_idx == CNT_W'(b))
        merged[b*8 +: 8] = mem_rdat_i;
    end
  end

  // Main controller: grant, walk the byte addresses, assemble read data, pulse acks.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      last_gnt   <= IDXW'(NPORT - 1);
      cur_gnt    <= '0;
      k          <= '0;
      last_k     <= '0;
      cap_idx    <= '0;
      rbuf       <= '0;
      wbuf       <= '0;
      rack_o     <= '0;
      wack_o     <= 1'b0;
      rdat_o     <= '0;
      mem_adr_o  <= '0;
      mem_we_o   <= 1'b0;
      mem_wdat_o <= '0;
    end else begin
      rack_o <= '0;
      wack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wreq_live) begin
            state      <= ST_WR;
            mem_adr_o  <= wadr_i;
            mem_we_o   <= 1'b1;
            mem_wdat_o <= wdat_i[7:0];
            wbuf       <= wdat_i >> 8;
            k          <= '0;
            last_k     <= CNT_W'(eff_count(int'(wcnt_i), MAXB) - 1);
          end else if (|rreq_live) begin
            state     <= ST_RD;
            cur_gnt   <= gnt;
            last_gnt  <= sel_idx;
            mem_adr_o <= sel_adr;
            k         <= '0;
            cap_idx   <= '0;
            rbuf      <= '0;
            last_k    <= CNT_W'(eff_count(int'(sel_cnt), MAXB) - 1);
          end
        end
        ST_RD: begin
          if (k != '0) begin
            rbuf    <= merged;
            cap_idx <= cap_idx + CNT_W'(1);
          end
          if (k == last_k) begin
            state <= ST_RDW;
          end else begin
            k         <= k + CNT_W'(1);
            mem_adr_o <= mem_adr_o + ADR_W'(1);
          end
        end
        ST_RDW: begin
          rdat_o <= merged;
          rack_o <= cur_gnt;
          state  <= ST_IDLE;
        end
        ST_WR: begin
          if (k == last_k) begin
            mem_we_o <= 1'b0;
            wack_o   <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            k          <= k + CNT_W'(1);
            mem_adr_o  <= mem_adr_o + ADR_W'(1);
            mem_wdat_o <= wbuf[7:0];
            wbuf       <= wbuf >> 8;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a behavioural single-byte synchronous RAM.
module tb_mem_port_arb;

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  rreq_i;
  logic [63:0] radr_i;
  logic [7:0]  rcnt_i;
  logic [3:0]  rack_o;
  logic [23:0] rdat_o;
  logic        wreq_i;
  logic [15:0] wadr_i;
  logic [1:0]  wcnt_i;
  logic [23:0] wdat_i;
  logic        wack_o;
  logic        stl_o;
  logic [15:0] mem_adr_o;
  logic        mem_we_o;
  logic [7:0]  mem_wdat_o;
  logic [7:0]  mem_rdat_i;

  logic [7:0]  ram [65536];

  int test_count;
  int fail_count;

  mem_port_arb #(
    .NPORT (4),
    .ADR_W (16),
    .MAXB  (3)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rreq_i     (rreq_i),
    .radr_i     (radr_i),
    .rcnt_i     (rcnt_i),
    .rack_o     (rack_o),
    .rdat_o     (rdat_o),
    .wreq_i     (wreq_i),
    .wadr_i     (wadr_i),
    .wcnt_i     (wcnt_i),
    .wdat_i     (wdat_i),
    .wack_o     (wack_o),
    .stl_o      (stl_o),
    .mem_adr_o  (mem_adr_o),
    .mem_we_o   (mem_we_o),
    .mem_wdat_o (mem_wdat_o),
    .mem_rdat_i (mem_rdat_i)
  );

  // 100 MHz clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // RAM: write on the edge, read data appears the cycle after the address.
  always @(posedge clk_i) begin
    if (mem_we_o)
      ram[mem_adr_o] <= mem_wdat_o;
    mem_rdat_i <= ram[mem_adr_o];
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [3:0] order [6];
    logic [3:0] exp_order [6];
    int nack;

    test_count = 0;
    fail_count = 0;
    rst_i  = 1'b0;
    rreq_i = '0;
    radr_i = '0;
    rcnt_i = '0;
    wreq_i = 1'b0;
    wadr_i = '0;
    wcnt_i = '0;
    wdat_i = '0;
    for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    ram[16'h1234] = 8'hAA;
    ram[16'h1235] = 8'hBB;
    ram[16'h1236] = 8'hCC;
    ram[16'hFFFF] = 8'h11;
    ram[16'h0000] = 8'h22;
    ram[16'h0100] = 8'hEE;
    ram[16'h0101] = 8'hEE;
    ram[16'h0102] = 8'hEE;

    // Reset state.
    repeat (3) tick;
    check("rst_rack", 32'(rack_o), 32'h0);
    check("rst_wack", 32'(wack_o), 32'h0);
    check("rst_rdat", 32'(rdat_o), 32'h0);
    check("rst_adr", 32'(mem_adr_o), 32'h0);
    check("rst_we", 32'(mem_we_o), 32'h0);
    check("rst_stl", 32'(stl_o), 32'h0);
    rst_i = 1'b1;
    tick;

    // Port 1 reads three bytes from 0x1234.
    radr_i[16 +: 16] = 16'h1234;
    rcnt_i[2 +: 2]   = 2'd3;
    rreq_i           = 4'b0010;
    #1;
    check("a_stl_t0", 32'(stl_o), 32'h1);
    tick;
    check("a_adr_t1", 32'(mem_adr_o), 32'h1234);
    tick;
    check("a_adr_t2", 32'(mem_adr_o), 32'h1235);
    tick;
    check("a_adr_t3", 32'(mem_adr_o), 32'h1236);
    check("a_we_rd", 32'(mem_we_o), 32'h0);
    tick;
    check("a_rack_t4", 32'(rack_o), 32'h0);
    tick;
    check("a_rack_t5", 32'(rack_o), 32'h2);
    check("a_rdat_t5", 32'(rdat_o), 32'hCCBBAA);
    check("a_stl_t5", 32'(stl_o), 32'h0);
    rreq_i = '0;
    tick;
    check("a_rack_t6", 32'(rack_o), 32'h0);

    // Port 0 reads two bytes across the address wrap.
    radr_i = '0;
    rcnt_i = '0;
    radr_i[0 +: 16] = 16'hFFFF;
    rcnt_i[0 +: 2]  = 2'd2;
    rreq_i          = 4'b0001;
    tick;
    check("b_adr_t1", 32'(mem_adr_o), 32'hFFFF);
    tick;
    check("b_adr_t2", 32'(mem_adr_o), 32'h0000);
    tick;
    check("b_rack_t3", 32'(rack_o), 32'h0);
    tick;
    check("b_rack_t4", 32'(rack_o), 32'h1);
    check("b_rdat_t4", 32'(rdat_o), 32'h002211);
    rreq_i = '0;
    tick;

    // Port 2 with a zero count fetches exactly one byte.
    radr_i = '0;
    rcnt_i = '0;
    radr_i[32 +: 16] = 16'h1234;
    rreq_i           = 4'b0100;
    tick;
    check("c_adr_t1", 32'(mem_adr_o), 32'h1234);
    tick;
    check("c_rack_t2", 32'(rack_o), 32'h0);
    check("c_rdat_hold", 32'(rdat_o), 32'h002211);
    tick;
    check("c_rack_t3", 32'(rack_o), 32'h4);
    check("c_rdat_t3", 32'(rdat_o), 32'h0000AA);
    rreq_i = '0;
    tick;

    // Write and read arrive together: the write goes first, the read sees its data.
    radr_i = '0;
    rcnt_i = '0;
    radr_i[0 +: 16] = 16'h0010;
    rcnt_i[0 +: 2]  = 2'd2;
    wadr_i = 16'h0010;
    wcnt_i = 2'd2;
    wdat_i = 24'h005A5A;
    wreq_i = 1'b1;
    rreq_i = 4'b0001;
    tick;
    check("d_we_t1", 32'(mem_we_o), 32'h1);
    check("d_adr_t1", 32'(mem_adr_o), 32'h0010);
    check("d_wdat_t1", 32'(mem_wdat_o), 32'h5A);
    tick;
    check("d_adr_t2", 32'(mem_adr_o), 32'h0011);
    check("d_wack_t2", 32'(wack_o), 32'h0);
    tick;
    check("d_wack_t3", 32'(wack_o), 32'h1);
    check("d_we_t3", 32'(mem_we_o), 32'h0);
    check("d_rack_t3", 32'(rack_o), 32'h0);
    wreq_i = 1'b0;
    tick;
    check("d_we_t4", 32'(mem_we_o), 32'h0);
    check("d_radr_t4", 32'(mem_adr_o), 32'h0010);
    repeat (2) tick;
    check("d_rack_t6", 32'(rack_o), 32'h0);
    tick;
    check("d_rack_t7", 32'(rack_o), 32'h1);
    check("d_rdat_t7", 32'(rdat_o), 32'h005A5A);
    rreq_i = '0;
    tick;

    // Fresh reset, then ports 0, 2 and 3 request continuously.
    rst_i = 1'b0;
    tick;
    rst_i = 1'b1;
    tick;
    radr_i = '0;
    rcnt_i = 8'b01_01_01_01;
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0100;
    exp_order[2] = 4'b1000;
    exp_order[3] = 4'b0001;
    exp_order[4] = 4'b0100;
    exp_order[5] = 4'b1000;
    for (int i = 0; i < 6; i++) order[i] = '0;
    nack = 0;
    rreq_i = 4'b1101;
    for (int c = 0; c < 40 && nack < 6; c++) begin
      tick;
      if (rack_o != '0) begin
        order[nack] = rack_o;
        nack++;
        if (nack == 6) rreq_i = '0;
      end
    end
    for (int i = 0; i < 6; i++)
      check($sformatf("e_rr_%0d", i), 32'(order[i]), 32'(exp_order[i]));
    repeat (4) tick;
    check("e_quiet_rack", 32'(rack_o), 32'h0);

    // Three-byte write aborted by reset after the first byte.
    wadr_i = 16'h0100;
    wcnt_i = 2'd3;
    wdat_i = 24'h332211;
    wreq_i = 1'b1;
    tick;
    check("f_adr_t1", 32'(mem_adr_o), 32'h0100);
    check("f_wdat_t1", 32'(mem_wdat_o), 32'h11);
    tick;
    check("f_wdat_t2", 32'(mem_wdat_o), 32'h22);
    rst_i  = 1'b0;
    wreq_i = 1'b0;
    #1;
    check("f_rst_we", 32'(mem_we_o), 32'h0);
    check("f_rst_adr", 32'(mem_adr_o), 32'h0);
    check("f_rst_wdat", 32'(mem_wdat_o), 32'h0);
    check("f_rst_rdat", 32'(rdat_o), 32'h0);
    check("f_rst_rack", 32'(rack_o), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick;
      check($sformatf("f_wack_%0d", c), 32'(wack_o), 32'h0);
    end
    rst_i = 1'b1;
    tick;
    check("f_wack_after", 32'(wack_o), 32'h0);
    check("f_ram_0100", 32'(ram[16'h0100]), 32'h11);
    check("f_ram_0101", 32'(ram[16'h0101]), 32'hEE);
    check("f_ram_0102", 32'(ram[16'h0102]), 32'hEE);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
